aes_v3_lanes: RTL and testbench

AES_V3_LANES -- requirements
Module: aes_v3_lanes

---
 rtl/aes_v3_lanes.sv | 184 ++++++++++++++++++
 tb/tb_aes_v3_lanes.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_v3_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aes_v3_lanes                                           |
// | Description : Byte-lane AES SubBytes / MixColumns unit. Processes    |
// |               LANES bytes per beat over 4/LANES beats, with an      |
// |               optional inverse path selected by enc=0.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module aes_v3_lanes #(
   parameter int DECRYPT_EN = 1,
   parameter int LANES      = 1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        valid,
   input  logic        flush,
   input  logic        sub,
   input  logic        enc,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        ready,
   output logic        busy,
   output logic [31:0] rd
);

   localparam int         c_beats = 4 / LANES;
   localparam logic [1:0] c_last  = 2'(c_beats - 1);

   // Beat counter: IDLE doubles as beat 0, so the encoding equals the beat index.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2,
      BEAT3 = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_res;
   logic [31:0] w_full;
   logic [1:0]  w_beat;
   logic        w_act;
   logic        w_final;
   logic [7:0]  w_sbin   [4];
   logic [7:0]  w_col    [4];
   logic [7:0]  w_lane   [LANES];
   logic [1:0]  w_lane_k [LANES];

   // ---------------- GF(2^8) helpers, polynomial 0x11b ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] aff_fwd(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] aff_inv(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   endfunction

   function automatic logic [7:0] mix_fwd(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
      return xtime(a) ^ xtime(b) ^ b ^ c ^ d;
   endfunction

   function automatic logic [7:0] mix_inv(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
      return gf_mul(8'h0e, a) ^ gf_mul(8'h0b, b) ^ gf_mul(8'h0d, c) ^ gf_mul(8'h09, d);
   endfunction

   // ---------------- operand byte maps ----------------
   assign w_sbin[0] = rs1[7:0];
   assign w_sbin[1] = rs2[15:8];
   assign w_sbin[2] = rs1[23:16];
   assign w_sbin[3] = rs2[31:24];

   assign w_col[0]  = rs1[7:0];
   assign w_col[1]  = rs1[15:8];
   assign w_col[2]  = rs2[23:16];
   assign w_col[3]  = rs2[31:24];

   assign w_beat = r_state;

   // One S-box and one (or two) MixColumns byte units per lane.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [1:0] w_k, w_k1, w_k2, w_k3;
      logic [7:0] w_x, w_inv_in, w_inv_out, w_sb, w_fmix, w_mix;

      // Byte index handled by this lane in the current beat (wraps mod 4).
      assign w_k  = w_beat * 2'(LANES) + 2'(l);
      assign w_k1 = w_k + 2'd1;
      assign w_k2 = w_k + 2'd2;
      assign w_k3 = w_k + 2'd3;

      assign w_x       = w_sbin[w_k];
      assign w_fmix    = mix_fwd(w_col[w_k], w_col[w_k1], w_col[w_k2], w_col[w_k3]);
      assign w_inv_out = gf_inv(w_inv_in);

      if (DECRYPT_EN != 0) begin : g_dec
         logic       w_inv;
         logic [7:0] w_imix;
         assign w_inv    = ~enc;
         assign w_imix   = mix_inv(w_col[w_k], w_col[w_k1], w_col[w_k2], w_col[w_k3]);
         // Forward and inverse S-box share the field inverter.
         assign w_inv_in = w_inv ? aff_inv(w_x) : w_x;
         assign w_sb     = w_inv ? w_inv_out : aff_fwd(w_inv_out);
         assign w_mix    = w_inv ? w_imix : w_fmix;
      end else begin : g_enc_only
         assign w_inv_in = w_x;
         assign w_sb     = aff_fwd(w_inv_out);
         assign w_mix    = w_fmix;
      end

      assign w_lane[l]   = sub ? w_sb : w_mix;
      assign w_lane_k[l] = w_k;
   end

   // Sequencing and handshake outputs; flush overrides everything.
   always_comb begin
      w_act   = g_resetn & (valid | (r_state != IDLE));
      w_final = (w_beat == c_last);
      ready   = w_act & w_final & ~flush;
      busy    = (r_state != IDLE);
      w_next  = r_state;
      if (flush) begin
         w_next = IDLE;
      end else if (w_act) begin
         if (w_final) w_next = IDLE;
         else         w_next = state_t'(w_beat + 2'd1);
      end
   end

   // Beat-counter state register.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) r_state <= IDLE;
      else           r_state <= w_next;
   end

   // Merge the current beat's lane bytes over the earlier registered bytes.
   always_comb begin
      w_full = r_res;
      for (int l = 0; l < LANES; l++) begin
         w_full[{w_lane_k[l], 3'b000} +: 8] = w_lane[l];
      end
   end

   // Capture partial results in non-final beats; drop them on flush.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn)                r_res <= 32'h0;
      else if (flush)               r_res <= 32'h0;
      else if (w_act && !w_final)   r_res <= w_full;
   end

   assign rd = ready ? w_full : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_aes_v3_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_aes_v3_lanes                                        |
// | Description : Self-checking bench for aes_v3_lanes; four instances  |
// |               (LANES 1/2/4, and 4 without decrypt) against a        |
// |               table-based cycle model plus directed vectors.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_aes_v3_lanes;

   localparam int c_lanes [4] = '{1, 2, 4, 4};
   localparam int c_dec   [4] = '{1, 1, 1, 0};

   logic        g_clk;
   logic        g_resetn;
   logic        valid_v [4];
   logic        flush_v [4];
   logic        sub_v   [4];
   logic        enc_v   [4];
   logic [31:0] rs1_v   [4];
   logic [31:0] rs2_v   [4];
   logic        ready_v [4];
   logic        busy_v  [4];
   logic [31:0] rd_v    [4];

   logic [7:0]  sb  [256];
   logic [7:0]  isb [256];
   int          m_pos [4];
   int          n_checks;
   int          n_err;

   for (genvar i = 0; i < 4; i++) begin : g_dut
      aes_v3_lanes #(.DECRYPT_EN(c_dec[i]), .LANES(c_lanes[i])) u_dut (
         .g_clk    (g_clk),
         .g_resetn (g_resetn),
         .valid    (valid_v[i]),
         .flush    (flush_v[i]),
         .sub      (sub_v[i]),
         .enc      (enc_v[i]),
         .rs1      (rs1_v[i]),
         .rs2      (rs2_v[i]),
         .ready    (ready_v[i]),
         .busy     (busy_v[i]),
         .rd       (rd_v[i])
      );
   end

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // Carry-less product then long-division reduction by 0x11b.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   // S-box from brute-force inverse and the affine bit equations.
   task automatic build_tables();
      logic [7:0] inv, s, cst;
      cst = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                 ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ cst[i];
         sb[x]  = s;
         isb[s] = 8'(x);
      end
   endtask

   function automatic logic [31:0] golden(input int i, input logic s, input logic e,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [7:0] x [4];
      logic [7:0] y [4];
      bit inv;
      inv = (c_dec[i] != 0) && !e;
      if (s) begin
         x = '{a[7:0], b[15:8], a[23:16], b[31:24]};
         for (int k = 0; k < 4; k++) y[k] = inv ? isb[x[k]] : sb[x[k]];
      end else begin
         x = '{a[7:0], a[15:8], b[23:16], b[31:24]};
         for (int k = 0; k < 4; k++) begin
            if (inv)
               y[k] = gmul(8'h0e, x[k]) ^ gmul(8'h0b, x[(k+1)%4])
                    ^ gmul(8'h0d, x[(k+2)%4]) ^ gmul(8'h09, x[(k+3)%4]);
            else
               y[k] = gmul(8'h02, x[k]) ^ gmul(8'h03, x[(k+1)%4])
                    ^ x[(k+2)%4] ^ x[(k+3)%4];
         end
      end
      return {y[3], y[2], y[1], y[0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Cycle model: an operation accepted with m_pos=0 finishes 4/LANES-1 cycles later.
   initial begin
      for (int i = 0; i < 4; i++) m_pos[i] = 0;
      forever begin
         @(negedge g_clk);
         for (int i = 0; i < 4; i++) begin
            int beats;
            bit act, er;
            beats = 4 / c_lanes[i];
            act   = g_resetn && (valid_v[i] || m_pos[i] != 0);
            er    = act && !flush_v[i] && (m_pos[i] == beats - 1);
            chk($sformatf("dut%0d ready", i), 32'(ready_v[i]), 32'(er));
            chk($sformatf("dut%0d busy", i), 32'(busy_v[i]), 32'(g_resetn && m_pos[i] != 0));
            if (!er)
               chk($sformatf("dut%0d rd idle", i), rd_v[i], 32'h0);
            else if (valid_v[i])
               chk($sformatf("dut%0d rd", i), rd_v[i],
                   golden(i, sub_v[i], enc_v[i], rs1_v[i], rs2_v[i]));
            if (!g_resetn || flush_v[i] || (act && m_pos[i] == beats - 1)) m_pos[i] = 0;
            else if (act) m_pos[i] = m_pos[i] + 1;
         end
      end
   end

   task automatic wait_ready(input int i, input int lat, input logic [31:0] exp_rd,
                             input bit chk_rd, input string nm);
      bit seen;
      seen = 0;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge g_clk);
         if (ready_v[i]) begin
            seen = 1;
            chk({nm, " latency"}, 32'(c), 32'(lat));
            if (chk_rd) chk({nm, " rd"}, rd_v[i], exp_rd);
         end
      end
      if (!seen) begin
         n_checks++;
         n_err++;
         $display("FAIL %s timeout: got no ready, required ready within 8 cycles", nm);
      end
   endtask

   task automatic op(input int i, input logic s, input logic e, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] exp_rd,
                     input string nm);
      @(posedge g_clk); #1;
      for (int j = 0; j < 4; j++) begin
         valid_v[j] = (j == i);
         flush_v[j] = 1'b0;
      end
      sub_v[i] = s; enc_v[i] = e; rs1_v[i] = a; rs2_v[i] = b;
      wait_ready(i, lat, exp_rd, 1'b1, nm);
   endtask

   task automatic idle(input int n);
      @(posedge g_clk); #1;
      for (int j = 0; j < 4; j++) begin
         valid_v[j] = 1'b0;
         flush_v[j] = 1'b0;
      end
      repeat (n) @(posedge g_clk);
   endtask

   initial begin
      int nrdy;
      n_checks = 0;
      n_err    = 0;
      g_resetn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid_v[i] = 0; flush_v[i] = 0; sub_v[i] = 0; enc_v[i] = 1;
         rs1_v[i] = 32'h0; rs2_v[i] = 32'h0;
      end
      build_tables();

      // Pin the model to known constants.
      chk("model S(00)", 32'(sb[0]), 32'h63);
      chk("model S(53)", 32'(sb[8'h53]), 32'hed);
      chk("model Sinv(00)", 32'(isb[0]), 32'h52);
      chk("model sbox vec", golden(0, 1, 1, 32'h00010000, 32'hff005300), 32'h167ced63);
      chk("model mix vec", golden(1, 0, 1, 32'h000013db, 32'h45530000), 32'hbca14d8e);

      #12;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset ready %0d", i), 32'(ready_v[i]), 32'h0);
         chk($sformatf("reset busy %0d", i), 32'(busy_v[i]), 32'h0);
         chk($sformatf("reset rd %0d", i), rd_v[i], 32'h0);
      end
      #11 g_resetn = 1'b1;

      op(0, 1, 1, 32'h00010000, 32'hff005300, 3, 32'h167ced63, "L1 sbox fwd");
      op(0, 1, 0, 32'h00000063, 32'h00000000, 3, 32'h52525200, "L1 sbox inv b2b");
      op(1, 0, 1, 32'h000013db, 32'h45530000, 1, 32'hbca14d8e, "L2 mix fwd");
      op(1, 0, 0, 32'h00007e4d, 32'hf8bd0000, 1, 32'h4c31262d, "L2 mix inv");
      op(1, 1, 0, 32'h00000063, 32'h00000000, 1, 32'h52525200, "L2 sbox inv");
      op(2, 0, 0, 32'h00004d8e, 32'hbca10000, 0, 32'h455313db, "L4 mix inv");
      op(2, 0, 1, 32'h0000d4d4, 32'hd5d40000, 0, 32'hd6d7d5d5, "L4 mix fwd");
      op(3, 0, 0, 32'h000013db, 32'h45530000, 0, 32'hbca14d8e, "L4 fwd-only mix enc0");
      op(3, 1, 0, 32'h00010000, 32'hff005300, 0, 32'h167ced63, "L4 fwd-only sbox enc0");
      op(0, 0, 0, 32'h00004d8e, 32'hbca10000, 3, 32'h455313db, "L1 mix inv");
      op(0, 0, 1, 32'h00000af2, 32'h5c220000, 3, 32'h9d58dc9f, "L1 mix fwd");
      idle(2);

      // valid dropped after acceptance: the operation still completes.
      @(posedge g_clk); #1;
      valid_v[0] = 1; sub_v[0] = 1; enc_v[0] = 1;
      rs1_v[0] = 32'h00010000; rs2_v[0] = 32'hff005300;
      @(posedge g_clk); #1;
      valid_v[0] = 0;
      wait_ready(0, 2, 32'h0, 1'b0, "L1 valid drop");
      idle(2);

      // flush in BEAT2, then a new operation accepted immediately.
      @(posedge g_clk); #1;
      valid_v[0] = 1; sub_v[0] = 0; enc_v[0] = 1;
      rs1_v[0] = 32'h000013db; rs2_v[0] = 32'h45530000;
      @(posedge g_clk); #1;
      @(posedge g_clk); #1;
      flush_v[0] = 1;
      #1;
      chk("L1 flush ready", 32'(ready_v[0]), 32'h0);
      chk("L1 flush busy", 32'(busy_v[0]), 32'h1);
      @(posedge g_clk); #1;
      flush_v[0] = 0; sub_v[0] = 1; enc_v[0] = 0;
      rs1_v[0] = 32'h00000063; rs2_v[0] = 32'h0;
      #1;
      chk("L1 post-flush busy", 32'(busy_v[0]), 32'h0);
      chk("L1 post-flush ready", 32'(ready_v[0]), 32'h0);
      wait_ready(0, 3, 32'h52525200, 1'b1, "L1 after flush");
      idle(2);

      // flush on LANES=4 suppresses the same-cycle ready.
      @(posedge g_clk); #1;
      valid_v[2] = 1; flush_v[2] = 1; sub_v[2] = 0; enc_v[2] = 1;
      rs1_v[2] = 32'h000013db; rs2_v[2] = 32'h45530000;
      #1;
      chk("L4 flush ready", 32'(ready_v[2]), 32'h0);
      @(posedge g_clk); #1;
      flush_v[2] = 0;
      #1;
      chk("L4 unflushed ready", 32'(ready_v[2]), 32'h1);
      chk("L4 unflushed rd", rd_v[2], 32'hbca14d8e);
      idle(2);

      // reset asserted in BEAT1.
      @(posedge g_clk); #1;
      valid_v[0] = 1; sub_v[0] = 0; enc_v[0] = 1;
      rs1_v[0] = 32'h00000af2; rs2_v[0] = 32'h5c220000;
      @(posedge g_clk); #1;
      chk("L1 BEAT1 busy", 32'(busy_v[0]), 32'h1);
      #1;
      g_resetn = 1'b0;
      valid_v[0] = 0;
      #1;
      chk("L1 reset ready", 32'(ready_v[0]), 32'h0);
      chk("L1 reset busy", 32'(busy_v[0]), 32'h0);
      chk("L1 reset rd", rd_v[0], 32'h0);
      @(posedge g_clk); #3;
      g_resetn = 1'b1;
      nrdy = 0;
      repeat (5) begin
         @(negedge g_clk);
         if (ready_v[0]) nrdy++;
      end
      chk("L1 no ready after reset", 32'(nrdy), 32'h0);

      // Model-checked random operations across all instances.
      for (int n = 0; n < 8; n++) begin
         int i;
         logic s, e;
         logic [31:0] a, b;
         i = n % 4;
         s = 1'($urandom_range(0, 1));
         e = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         op(i, s, e, a, b, 4 / c_lanes[i] - 1, golden(i, s, e, a, b),
            $sformatf("rand%0d", n));
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
